// File: rtl/sensor_pkg.sv
// Shared types and defaults for the sensor error monitor slice.
package sensor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } monitor_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_CNT_WIDTH       = 8;

endpackage

// File: rtl/sync_high.sv
// Two-flop synchronizer for a single asynchronous bit; both flops clear to 0 on reset.
module sync_high (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sensor_error_monitor.sv
// Synchronizes and debounces the detector error bit, then raises a sticky alarm
// and counts qualified error episodes with a saturating counter.
import sensor_pkg::*;

module sensor_error_monitor #(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH       = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 error_in,
  input  logic                 clear,
  output logic                 error_valid,
  output logic                 alarm,
  output logic [CNT_WIDTH-1:0] event_count,
  output logic                 overflow
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0]        DMAX = DW'(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;

  logic           err_s;
  monitor_state_t state, state_nxt;
  logic [DW-1:0]  dcnt, dcnt_nxt;
  logic           event_edge;

  sync_high u_sync (
    .clk (clk),
    .rst (rst),
    .d   (error_in),
    .q   (err_s)
  );

  always_comb begin
    state_nxt  = state;
    dcnt_nxt   = dcnt;
    event_edge = 1'b0;
    unique case (state)
      IDLE: begin
        if (err_s) begin
          state_nxt = QUALIFY;
          dcnt_nxt  = DW'(1);
        end
      end
      QUALIFY: begin
        if (!err_s) begin
          state_nxt = IDLE;
          dcnt_nxt  = '0;
        end else if (dcnt == DMAX) begin
          state_nxt  = ACTIVE;
          event_edge = 1'b1;
        end else begin
          dcnt_nxt = dcnt + 1'b1;
        end
      end
      ACTIVE: begin
        if (!err_s) begin
          state_nxt = RELEASE;
          dcnt_nxt  = DW'(1);
        end
      end
      RELEASE: begin
        if (err_s) begin
          state_nxt = ACTIVE;
          dcnt_nxt  = '0;
        end else if (dcnt == DMAX) begin
          state_nxt = IDLE;
        end else begin
          dcnt_nxt = dcnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        dcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  // An event coinciding with clear restarts the history at one event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm       <= 1'b0;
      overflow    <= 1'b0;
      event_count <= '0;
    end else if (event_edge) begin
      alarm <= 1'b1;
      if (clear) begin
        event_count <= CNT_WIDTH'(1);
        overflow    <= 1'b0;
      end else if (event_count == CMAX) begin
        overflow <= 1'b1;
      end else begin
        event_count <= event_count + 1'b1;
      end
    end else if (clear) begin
      alarm       <= 1'b0;
      overflow    <= 1'b0;
      event_count <= '0;
    end
  end

  assign error_valid = (state == ACTIVE) || (state == RELEASE);

endmodule

// File: tb/tb_sensor_error_monitor.sv
// Bench for sensor_error_monitor: two instances (default, and D=1 with a 2-bit
// counter) driven in parallel and compared against a run-length reference model.
module tb_sensor_error_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       error_in;
  logic       clear;
  logic       ev0, al0, ov0, ev1, al1, ov1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sensor_error_monitor dut0 (
    .clk(clk), .rst(rst), .error_in(error_in), .clear(clear),
    .error_valid(ev0), .alarm(al0), .event_count(cnt0), .overflow(ov0)
  );

  sensor_error_monitor #(.DEBOUNCE_CYCLES(1), .CNT_WIDTH(2)) dut1 (
    .clk(clk), .rst(rst), .error_in(error_in), .clear(clear),
    .error_valid(ev1), .alarm(al1), .event_count(cnt1), .overflow(ov1)
  );

  // Reference: err_s is error_in delayed two edges; an episode starts once err_s
  // has been high for D+1 consecutive edges and ends after D+1 consecutive lows.
  int dmax[2] = '{4, 1};
  int cmax[2] = '{255, 3};
  int s1, s2;
  int hr[2], lr[2], cnt[2];
  bit ep[2], al[2], ov[2];

  task automatic model_reset();
    s1 = 0; s2 = 0;
    for (int k = 0; k < 2; k++) begin
      hr[k] = 0; lr[k] = 0; cnt[k] = 0; ep[k] = 0; al[k] = 0; ov[k] = 0;
    end
  endtask

  function automatic bit event_next(int k);
    return !ep[k] && (s2 != 0) && (hr[k] == dmax[k]);
  endfunction

  task automatic model_edge(input bit err, input bit clr);
    int e;
    bit ev;
    e = s2; s2 = s1; s1 = int'(err);
    for (int k = 0; k < 2; k++) begin
      ev = 0;
      if (!ep[k]) begin
        hr[k] = (e != 0) ? hr[k] + 1 : 0;
        if (hr[k] == dmax[k] + 1) begin
          ep[k] = 1; ev = 1; lr[k] = 0;
        end
      end else begin
        lr[k] = (e != 0) ? 0 : lr[k] + 1;
        if (lr[k] == dmax[k] + 1) begin
          ep[k] = 0; hr[k] = 0;
        end
      end
      if (ev) begin
        al[k] = 1;
        if (clr) begin
          cnt[k] = 1; ov[k] = 0;
        end else if (cnt[k] == cmax[k]) ov[k] = 1;
        else cnt[k] = cnt[k] + 1;
      end else if (clr) begin
        al[k] = 0; ov[k] = 0; cnt[k] = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid0"}, 32'(ev0), 32'(ep[0]));
    check({tag, ".alarm0"}, 32'(al0), 32'(al[0]));
    check({tag, ".count0"}, 32'(cnt0), cnt[0]);
    check({tag, ".ovf0"},   32'(ov0), 32'(ov[0]));
    check({tag, ".valid1"}, 32'(ev1), 32'(ep[1]));
    check({tag, ".alarm1"}, 32'(al1), 32'(al[1]));
    check({tag, ".count1"}, 32'(cnt1), cnt[1]);
    check({tag, ".ovf1"},   32'(ov1), 32'(ov[1]));
  endtask

  task automatic step(input string tag, input bit err, input bit clr);
    error_in = err;
    clear    = clr;
    @(posedge clk);
    model_edge(err, clr);
    #1 check_all(tag);
  endtask

  task automatic run(input string tag, input bit err, input int n);
    for (int i = 0; i < n; i++) step(tag, err, 1'b0);
  endtask

  initial begin
    bit hit;
    bit lvl;
    int len;
    rst = 1'b1; error_in = 1'b0; clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    rst = 1'b0;

    // Qualified event, then release
    run("qualify", 1'b1, 10);
    run("release", 1'b0, 10);

    // Glitches shorter than the default qualification window
    run("glitch", 1'b1, 3);
    run("glitch", 1'b0, 10);
    run("glitch", 1'b1, 4);
    run("glitch", 1'b0, 10);

    // Drop-out inside an episode
    run("dropout", 1'b1, 8);
    run("dropout", 1'b0, 3);
    run("dropout", 1'b1, 6);
    run("dropout", 1'b0, 8);

    // Third episode, then asynchronous reset mid-cycle while active
    run("active3", 1'b1, 8);
    check("pre_rst_count0", 32'(cnt0), 32'd3);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    error_in = 1'b0;
    run("post_rst", 1'b0, 4);

    // Saturation of the 2-bit counter, then clear
    for (int n = 0; n < 5; n++) begin
      run("sat", 1'b1, 8);
      run("sat", 1'b0, 8);
    end
    check("sat_count1", 32'(cnt1), 32'd3);
    check("sat_ovf1", 32'(ov1), 32'd1);
    step("clear", 1'b0, 1'b1);
    step("clear_after", 1'b0, 1'b0);

    // Clear coinciding with an event edge on the default instance (count at 2)
    for (int n = 0; n < 2; n++) begin
      run("pre_sim", 1'b1, 8);
      run("pre_sim", 1'b0, 8);
    end
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (event_next(0)) begin
        step("simul", 1'b1, 1'b1);
        hit = 1'b1;
      end else begin
        step("simul_wait", 1'b1, 1'b0);
      end
    end
    check("simul_found", 32'(hit), 32'd1);
    check("simul_count0", 32'(cnt0), 32'd1);
    run("simul_tail", 1'b0, 8);

    // Randomized run lengths with occasional clears
    lvl = 1'b0;
    for (int r = 0; r < 80; r++) begin
      lvl = ~lvl;
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) step("rand", lvl, ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
